// File: rtl/scie_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : scie_issue_queue
//  Brief    : Issue/response queue for a fixed-latency pipelined SCIE unit.
//             Commands are issued in order. Each accepted command occupies a
//             credit until its response is consumed. A LATENCY-deep tag
//             pipeline pairs each pu_rd sample with its command, and a
//             DEPTH-entry FIFO holds the results for writeback.
//  Revision : 1.0 - initial release
// ============================================================================
module scie_issue_queue #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    // command channel from the core
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_insn,
    input  logic [31:0] cmd_rs1,
    input  logic [31:0] cmd_rs2,
    input  logic [4:0]  cmd_tag,
    input  logic        cmd_pipelined,
    // pipelined unit
    output logic        pu_valid,
    output logic [31:0] pu_insn,
    output logic [31:0] pu_rs1,
    output logic [31:0] pu_rs2,
    input  logic [31:0] pu_rd,
    // response channel to writeback
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_tag,
    output logic        resp_err,
    output logic        busy
);

    // Pointer width; DEPTH is a power of two, so pointers wrap naturally.
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counters must be able to represent DEPTH itself.
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0]        r_occ;       // in-flight + queued entries
    logic [LATENCY-1:0]        r_sr_valid;  // tag pipeline valid bits
    logic [LATENCY-1:0][4:0]   r_sr_tag;
    logic [LATENCY-1:0]        r_sr_err;

    logic [31:0]               r_fifo_data [DEPTH];
    logic [4:0]                r_fifo_tag  [DEPTH];
    logic                      r_fifo_err  [DEPTH];
    logic [c_ptr_w-1:0]        r_wr_ptr;
    logic [c_ptr_w-1:0]        r_rd_ptr;
    logic [c_cnt_w-1:0]        r_fifo_cnt;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic        w_accept;
    logic        w_pop;
    logic        w_push;
    logic [31:0] w_push_data;
    logic [4:0]  w_push_tag;
    logic        w_push_err;

    // Acceptance is gated by reset so a command presented during reset is
    // neither issued nor counted. Credits come from the registered
    // occupancy only, so a pop raises cmd_ready one cycle later.
    always_comb begin
        cmd_ready   = (r_occ < c_depth);
        w_accept    = cmd_valid & cmd_ready & ~reset;
        pu_valid    = w_accept & cmd_pipelined;
        pu_insn     = cmd_insn;
        pu_rs1      = cmd_rs1;
        pu_rs2      = cmd_rs2;
        busy        = (r_occ != '0);
        w_push      = r_sr_valid[LATENCY-1];
        w_push_tag  = r_sr_tag[LATENCY-1];
        w_push_err  = r_sr_err[LATENCY-1];
        // Non-pipelined commands never reach the unit; their result is zero.
        w_push_data = w_push_err ? 32'h0 : pu_rd;
    end

    // Head of the FIFO drives the response. Fields read zero when the FIFO
    // is empty so the response channel is clean out of reset.
    always_comb begin
        resp_valid = (r_fifo_cnt != '0);
        resp_data  = 32'h0;
        resp_tag   = 5'h0;
        resp_err   = 1'b0;
        if (resp_valid) begin
            resp_data = r_fifo_data[r_rd_ptr];
            resp_tag  = r_fifo_tag[r_rd_ptr];
            resp_err  = r_fifo_err[r_rd_ptr];
        end
        w_pop = resp_valid & resp_ready;
    end

    // ------------------------------------------------------------------
    // Occupancy counter: one credit per command from accept until pop.
    // ------------------------------------------------------------------
    // Credit accounting; simultaneous accept and pop cancel out.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_occ <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + c_cnt_one;
                2'b01:   r_occ <= r_occ - c_cnt_one;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: stage LATENCY-1 lines up with pu_rd for that command.
    // Every accepted command enters, pipelined or not, to keep order.
    // ------------------------------------------------------------------
    // Shift the {valid, tag, err} record one stage per cycle, never stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sr_valid <= '0;
            r_sr_tag   <= '0;
            r_sr_err   <= '0;
        end else begin
            r_sr_valid[0] <= w_accept;
            r_sr_tag[0]   <= cmd_tag;
            r_sr_err[0]   <= ~cmd_pipelined;
            for (int i = 1; i < LATENCY; i++) begin
                r_sr_valid[i] <= r_sr_valid[i-1];
                r_sr_tag[i]   <= r_sr_tag[i-1];
                r_sr_err[i]   <= r_sr_err[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO. Credits guarantee a free slot for every push, so the
    // push side never checks for full.
    // ------------------------------------------------------------------
    // Storage write; contents need no reset because the outputs are masked.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_push_data;
            r_fifo_tag[r_wr_ptr]  <= w_push_tag;
            r_fifo_err[r_wr_ptr]  <= w_push_err;
        end
    end

    // Pointers and entry count; push and pop may happen in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_cnt_one;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_cnt_one;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scie_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scie_issue_queue
//  Brief    : Self-checking bench for scie_issue_queue (LATENCY=1, DEPTH=4).
//             Directed per-cycle vector table plus streaming, pointer-wrap
//             and mid-operation reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scie_issue_queue;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_insn;
    logic [31:0] cmd_rs1;
    logic [31:0] cmd_rs2;
    logic [4:0]  cmd_tag;
    logic        cmd_pipelined;
    logic        pu_valid;
    logic [31:0] pu_insn;
    logic [31:0] pu_rs1;
    logic [31:0] pu_rs2;
    logic [31:0] pu_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        resp_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    scie_issue_queue #(.LATENCY(1), .DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_insn      (cmd_insn),
        .cmd_rs1       (cmd_rs1),
        .cmd_rs2       (cmd_rs2),
        .cmd_tag       (cmd_tag),
        .cmd_pipelined (cmd_pipelined),
        .pu_valid      (pu_valid),
        .pu_insn       (pu_insn),
        .pu_rs1        (pu_rs1),
        .pu_rs2        (pu_rs2),
        .pu_rd         (pu_rd),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag),
        .resp_err      (resp_err),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pipelined-unit model, one cycle latency: result = rs1 + rs2.
    // Junk when not issued so a wrongly used pu_rd shows up.
    always @(posedge clock) begin
        pu_rd <= pu_valid ? (pu_rs1 + pu_rs2) : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic        cv;
        logic        pip;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  tag;
        logic        rr;
        logic        e_ready;
        logic        e_pu;
        logic        e_rv;
        logic [31:0] e_data;
        logic [4:0]  e_tag;
        logic        e_err;
        logic        e_busy;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
    } resp_t;

    vec_t  vecs [19];
    resp_t sbq [$];

    function automatic vec_t mk(logic cv, logic pip, logic [31:0] rs1, logic [31:0] rs2,
                                logic [4:0] tag, logic rr, logic e_ready, logic e_pu,
                                logic e_rv, logic [31:0] e_data, logic [4:0] e_tag,
                                logic e_err, logic e_busy);
        vec_t v;
        v.cv = cv;  v.pip = pip; v.rs1 = rs1; v.rs2 = rs2; v.tag = tag; v.rr = rr;
        v.e_ready = e_ready; v.e_pu = e_pu; v.e_rv = e_rv; v.e_data = e_data;
        v.e_tag = e_tag; v.e_err = e_err; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Compare a consumed response against the oldest expected one.
    task automatic check_resp(input string name);
        resp_t e;
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: unexpected response tag=%0d data=0x%0h, none expected",
                     name, resp_tag, resp_data);
        end else begin
            e = sbq.pop_front();
            chk({name, "_tag"},  32'(resp_tag),  32'(e.tag));
            chk({name, "_data"}, resp_data,      e.data);
            chk({name, "_err"},  32'(resp_err),  32'(e.err));
        end
    endtask

    task automatic drive(input logic cv, input logic pip, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [4:0] tag, input logic rr);
        cmd_valid     = cv;
        cmd_pipelined = pip;
        cmd_rs1       = rs1;
        cmd_rs2       = rs2;
        cmd_tag       = tag;
        cmd_insn      = {rs2[15:0], rs1[15:0]} ^ 32'h0000_000B;
        resp_ready    = rr;
    endtask

    initial begin
        int got;
        int first_k;
        int sent;
        resp_t e;

        // Vector table: {inputs} | {ready, pu_valid, resp_valid, data, tag, err, busy}
        vecs[0]  = mk(H, H, 32'd5, 32'd7,   5'd3, L,  H, H, L, 32'd0,   5'd0, L, L);
        vecs[1]  = mk(H, L, 32'd1, 32'd2,   5'd9, L,  H, L, L, 32'd0,   5'd0, L, H);
        vecs[2]  = mk(L, L, 32'd0, 32'd0,   5'd0, L,  H, L, H, 32'd12,  5'd3, L, H);
        vecs[3]  = mk(L, L, 32'd0, 32'd0,   5'd0, H,  H, L, H, 32'd12,  5'd3, L, H);
        vecs[4]  = mk(L, L, 32'd0, 32'd0,   5'd0, L,  H, L, H, 32'd0,   5'd9, H, H);
        vecs[5]  = mk(L, L, 32'd0, 32'd0,   5'd0, H,  H, L, H, 32'd0,   5'd9, H, H);
        vecs[6]  = mk(L, L, 32'd0, 32'd0,   5'd0, L,  H, L, L, 32'd0,   5'd0, L, L);
        vecs[7]  = mk(H, H, 32'd0, 32'd100, 5'd0, L,  H, H, L, 32'd0,   5'd0, L, L);
        vecs[8]  = mk(H, H, 32'd1, 32'd100, 5'd1, L,  H, H, L, 32'd0,   5'd0, L, H);
        vecs[9]  = mk(H, H, 32'd2, 32'd100, 5'd2, L,  H, H, H, 32'd100, 5'd0, L, H);
        vecs[10] = mk(H, H, 32'd3, 32'd100, 5'd3, L,  H, H, H, 32'd100, 5'd0, L, H);
        vecs[11] = mk(H, H, 32'd4, 32'd100, 5'd4, L,  L, L, H, 32'd100, 5'd0, L, H);
        vecs[12] = mk(H, H, 32'd4, 32'd100, 5'd4, H,  L, L, H, 32'd100, 5'd0, L, H);
        vecs[13] = mk(H, H, 32'd4, 32'd100, 5'd4, L,  H, H, H, 32'd101, 5'd1, L, H);
        vecs[14] = mk(L, L, 32'd0, 32'd0,   5'd0, H,  L, L, H, 32'd101, 5'd1, L, H);
        vecs[15] = mk(L, L, 32'd0, 32'd0,   5'd0, H,  H, L, H, 32'd102, 5'd2, L, H);
        vecs[16] = mk(L, L, 32'd0, 32'd0,   5'd0, H,  H, L, H, 32'd103, 5'd3, L, H);
        vecs[17] = mk(L, L, 32'd0, 32'd0,   5'd0, H,  H, L, H, 32'd104, 5'd4, L, H);
        vecs[18] = mk(L, L, 32'd0, 32'd0,   5'd0, L,  H, L, L, 32'd0,   5'd0, L, L);

        // ---------------- reset state ----------------
        reset = 1'b1;
        drive(H, H, 32'd1, 32'd1, 5'd1, L);
        repeat (3) @(negedge clock);
        #1;
        chk("rst_cmd_ready",  32'(cmd_ready),  32'd1);
        chk("rst_pu_valid",   32'(pu_valid),   32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_resp_data",  resp_data,       32'd0);
        chk("rst_resp_tag",   32'(resp_tag),   32'd0);
        chk("rst_resp_err",   32'(resp_err),   32'd0);
        @(negedge clock);
        reset = 1'b0;

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].cv, vecs[i].pip, vecs[i].rs1, vecs[i].rs2, vecs[i].tag, vecs[i].rr);
            #1;
            chk($sformatf("v%0d_cmd_ready", i),  32'(cmd_ready),  32'(vecs[i].e_ready));
            chk($sformatf("v%0d_pu_valid", i),   32'(pu_valid),   32'(vecs[i].e_pu));
            chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_resp_data", i),  resp_data,       vecs[i].e_data);
            chk($sformatf("v%0d_resp_tag", i),   32'(resp_tag),   32'(vecs[i].e_tag));
            chk($sformatf("v%0d_resp_err", i),   32'(resp_err),   32'(vecs[i].e_err));
            chk($sformatf("v%0d_busy", i),       32'(busy),       32'(vecs[i].e_busy));
            chk($sformatf("v%0d_pu_insn", i),    pu_insn,         cmd_insn);
            chk($sformatf("v%0d_pu_rs1", i),     pu_rs1,          vecs[i].rs1);
            @(negedge clock);
        end

        // ---------------- streaming: 20 back-to-back, resp_ready=1 ----------------
        got = 0;
        first_k = -1;
        for (int k = 0; k < 40 && got < 20; k++) begin
            if (k < 20) drive(H, H, 32'(k * 3), 32'd1000, 5'(k), H);
            else        drive(L, L, 32'd0, 32'd0, 5'd0, H);
            #1;
            if (k < 20) chk($sformatf("stream_ready_%0d", k), 32'(cmd_ready), 32'd1);
            if (k >= 1 && k < 20) chk($sformatf("stream_busy_%0d", k), 32'(busy), 32'd1);
            if (resp_valid) begin
                if (first_k < 0) first_k = k;
                check_resp("stream");
                got++;
            end
            if (cmd_valid && cmd_ready) begin
                e.data = 32'(k * 3) + 32'd1000;
                e.tag  = 5'(k);
                e.err  = 1'b0;
                sbq.push_back(e);
            end
            @(negedge clock);
        end
        chk("stream_first_resp_cycle", 32'(first_k), 32'd2);
        chk("stream_resp_count",       32'(got),     32'd20);
        drive(L, L, 32'd0, 32'd0, 5'd0, L);
        @(negedge clock);
        sbq.delete();

        // ---------------- pointer wrap: 10 commands, random resp_ready ----------------
        got = 0;
        sent = 0;
        for (int k = 0; k < 300 && got < 10; k++) begin
            drive(logic'(sent < 10), logic'((sent % 3) != 2), 32'(sent * 17 + 1),
                  32'(sent + 40), 5'(sent + 10), logic'($urandom_range(0, 1)));
            #1;
            if (resp_valid && resp_ready) begin
                check_resp("wrap");
                got++;
            end
            if (cmd_valid && cmd_ready) begin
                e.err  = ((sent % 3) == 2);
                e.data = e.err ? 32'd0 : (32'(sent * 17 + 1) + 32'(sent + 40));
                e.tag  = 5'(sent + 10);
                sbq.push_back(e);
                sent++;
            end
            @(negedge clock);
        end
        chk("wrap_resp_count", 32'(got), 32'd10);
        drive(L, L, 32'd0, 32'd0, 5'd0, L);
        #1;
        chk("wrap_idle_busy", 32'(busy), 32'd0);
        @(negedge clock);
        sbq.delete();

        // ---------------- reset with 3 commands outstanding ----------------
        for (int k = 0; k < 3; k++) begin
            drive(H, H, 32'(k), 32'd5, 5'(20 + k), L);
            @(negedge clock);
        end
        reset = 1'b1;
        drive(H, H, 32'd9, 32'd9, 5'd30, L);
        #1;
        chk("mrst_pu_valid_in_reset", 32'(pu_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        drive(L, L, 32'd0, 32'd0, 5'd0, H);
        #1;
        chk("mrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mrst_busy",       32'(busy),       32'd0);
        chk("mrst_cmd_ready",  32'(cmd_ready),  32'd1);
        chk("mrst_resp_tag",   32'(resp_tag),   32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            #1;
            chk($sformatf("mrst_stale_%0d", k), 32'(resp_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scie_issue_queue.md
SCIE_ISSUE_QUEUE -- requirements
Module: scie_issue_queue

Interface
REQ-001 Parameter LATENCY, default 1, meaning fixed cycle count from pu_valid to valid pu_rd of the pipelined SCIE unit; legal range 1..4.
REQ-002 Parameter DEPTH, default 4, meaning response FIFO entries and maximum outstanding commands; power of two, 2..16.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  core presents a custom-instruction command.
REQ-006 cmd_ready  output  1  block accepts the command this cycle.
REQ-007 cmd_insn  input  32  instruction word.
REQ-008 cmd_rs1  input  32  first source operand.
REQ-009 cmd_rs2  input  32  second source operand.
REQ-010 cmd_tag  input  5  destination register index.
REQ-011 cmd_pipelined  input  1  decoder class bit; 1 = pipelined-class instruction.
REQ-012 pu_valid  output  1  issue strobe to pipelined unit.
REQ-013 pu_insn  output  32  instruction to pipelined unit.
REQ-014 pu_rs1  output  32  operand 1 to pipelined unit.
REQ-015 pu_rs2  output  32  operand 2 to pipelined unit.
REQ-016 pu_rd  input  32  result from pipelined unit, valid LATENCY cycles after pu_valid.
REQ-017 resp_valid  output  1  response available.
REQ-018 resp_ready  input  1  writeback consumes the response.
REQ-019 resp_data  output  32  result value.
REQ-020 resp_tag  output  5  destination register index.
REQ-021 resp_err  output  1  1 = command was not pipelined-class.
REQ-022 busy  output  1  occupancy counter nonzero.

Function
REQ-023 Accept = cmd_valid & cmd_ready; cmd_ready = (occ < DEPTH), occ a registered counter of in-flight plus queued entries.
REQ-024 pu_insn/pu_rs1/pu_rs2 combinationally equal cmd_insn/cmd_rs1/cmd_rs2; pu_valid = accept & cmd_pipelined.
REQ-025 Every accepted command enters a LATENCY-stage shift register carrying {valid, tag, err = ~cmd_pipelined}; no command is dropped or reordered.
REQ-026 When a stage-LATENCY entry is valid, it is pushed into the FIFO at that clock edge: data = pu_rd if err=0, data = 32'h0 if err=1.
REQ-027 Latency: command accepted in cycle T gives resp_valid=1 no earlier than cycle T+LATENCY+1.
REQ-028 FIFO head drives resp_data/resp_tag/resp_err; resp_valid = FIFO non-empty; head fields stay stable while resp_valid & ~resp_ready.
REQ-029 Pop = resp_valid & resp_ready; read/write pointers wrap modulo DEPTH.
REQ-030 occ += 1 on accept, -= 1 on pop, unchanged on both in same cycle; occ never exceeds DEPTH nor drops below 0.
REQ-031 Full: occ == DEPTH forces cmd_ready=0; a pop in that cycle raises cmd_ready in the next cycle, not combinationally.
REQ-032 Push and pop in the same cycle on a non-empty FIFO: both occur, count unchanged.
REQ-033 Push into an empty FIFO: resp_valid rises the following cycle; no same-cycle bypass.
REQ-034 resp_valid=1 with resp_ready=0 never blocks the shift register; credits guarantee the FIFO has space for every in-flight entry.

Reset
REQ-035 With reset=1 at a clock edge: occ=0, pointers=0, all shift-register valid bits=0, FIFO empty.
REQ-036 Outputs during/after reset: cmd_ready=1, resp_valid=0, pu_valid=0 (cmd_valid is ignored while reset=1), busy=0; resp_data/resp_tag/resp_err=0.
REQ-037 Reset mid-operation discards all in-flight and queued commands; no response for them ever appears.

Verification
REQ-038 LATENCY=1: accept pipelined insn with rs1=5, rs2=7, tag=3 at cycle T, pu_rd=12 at T+1 -> resp_valid=1 at T+2, resp_data=12, resp_tag=3, resp_err=0.
REQ-039 cmd_pipelined=0, tag=9 -> pu_valid=0; response with resp_err=1, resp_data=0, resp_tag=9, in order behind earlier commands.
REQ-040 DEPTH=4, resp_ready=0, issue 5 back-to-back -> 4 accepted, cmd_ready=0 from the cycle after the 4th accept; one pop -> cmd_ready=1 next cycle; tags 0..3 emerge in order.
REQ-041 Continuous cmd_valid and resp_ready=1 for 20 cycles -> one accept per cycle, occ stable at LATENCY+1, tags in order with no gaps.
REQ-042 Pointer wrap: 10 commands through DEPTH=4 with random resp_ready -> all 10 responses correct, in order.
REQ-043 Assert reset with 3 commands outstanding -> next cycle resp_valid=0, busy=0, cmd_ready=1; no stale response after release.
